// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential byte fetch through the
// memory arbiter into a small FIFO, with redirect support.
module ifetch_queue #(
  parameter int          M_WIDTH   = 8,
  parameter int          DEPTH     = 4,
  parameter logic [1:0]  MEM_ACC_8 = 2'b00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [M_WIDTH-1:0] flush_pc,
  output logic               mem_req,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic               mem_we,
  output logic [1:0]         mem_width,
  output logic [M_WIDTH-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic [M_WIDTH-1:0] mem_rdata,
  output logic [M_WIDTH-1:0] instr,
  output logic [M_WIDTH-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]      FULL   = CW'(DEPTH);
  localparam logic [CW-1:0]      C_ONE  = CW'(1);
  localparam logic [AW-1:0]      P_ONE  = AW'(1);
  localparam logic [M_WIDTH-1:0] PC_ONE = M_WIDTH'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]         r_state;
  logic               r_req;
  logic [M_WIDTH-1:0] r_addr;
  logic [M_WIDTH-1:0] r_pc;
  logic               r_discard;
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [CW-1:0]      r_cnt;
  logic [M_WIDTH-1:0] r_data [DEPTH];
  logic [M_WIDTH-1:0] r_tag  [DEPTH];

  logic w_nempty;
  logic w_issue;
  logic w_push;
  logic w_pop;

  assign w_nempty = (r_cnt != '0);
  assign w_issue  = (r_state == S_IDLE)
                 && (r_cnt < FULL)
                 && !flush;
  assign w_push   = (r_state == S_REQ)
                 && mem_ready
                 && !r_discard
                 && !flush;
  assign w_pop    = w_nempty
                 && instr_ready
                 && !flush;

  assign mem_req     = r_req;
  assign mem_addr    = r_addr;
  assign mem_we      = 1'b0;
  assign mem_width   = MEM_ACC_8;
  assign mem_wdata   = '0;
  assign instr_valid = w_nempty;
  assign instr       = w_nempty ? r_data[r_rd] : '0;
  assign instr_pc    = w_nempty ? r_tag[r_rd]  : '0;

  // Arbiter handshake: one request in flight, always run to completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_state   <= S_REL;
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        S_REL: begin
          if (!mem_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Fetch PC: redirect wins, otherwise advance on each kept byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (flush) begin
      r_pc <= flush_pc;
    end else if (w_push) begin
      r_pc <= r_pc + PC_ONE;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= r_wr;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + P_ONE;
      end
      if (w_pop) begin
        r_rd <= r_rd + P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Queue storage; reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr] <= mem_rdata;
      r_tag[r_wr]  <= r_addr;
    end
  end

endmodule
